// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/state enums, baud divider helper and default line rates.
// The transmitter imports the same package so both ends agree on DIV.
package uart_pkg;
    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115200;

    typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} parity_mode_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;

    // Rounded clocks per oversample tick.
    function automatic int calc_div(int clk_freq, int baud, int oversample);
        int den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction
endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: serial line in, word/flags/handshake out.
interface uart_rx_oversampled_if #(parameter int DATA_BITS = 8);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_error;
    logic                 framing_error;
    logic                 overrun;
    logic                 busy;

    modport master (input rx, rx_ready,
                    output rx_data, rx_valid, parity_error, framing_error, overrun, busy);
    modport slave  (output rx, rx_ready,
                    input rx_data, rx_valid, parity_error, framing_error, overrun, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 counter producing a one-clock tick on the last count.
// clr_i restarts the count so the tick phase can be locked to an external event.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-flop input sync, 3-sample majority per bit,
// optional parity, 1-2 stop bits, valid/ready output with error and overrun flags.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int BAUD        = DEFAULT_BAUD,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_oversampled_if.master  bus
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_RES  = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_FULL = BW'(DATA_BITS);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_e state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic s0_q, s0_d, s1_q, s1_d;
    logic perr_q, perr_d, ferr_q, ferr_d;
    logic stop_cnt_q, stop_cnt_d;
    logic done_q, done_d;
    logic valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
    logic tick, tick_clr, sample_mid, bit_end, maj;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    assign sample_mid = tick && (phase_q == PH_RES);
    assign bit_end    = tick && (phase_q == PH_LAST);
    // Third vote is the live sample at the resolve phase.
    assign maj = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        tick_clr   = 1'b0;

        if (tick) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (tick && phase_q == PH_S0) s0_d = rx_s_q;
        if (tick && phase_q == PH_S1) s1_d = rx_s_q;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d  = START;
                    tick_clr = 1'b1;
                    phase_d  = '0;
                    perr_d   = 1'b0;
                    ferr_d   = 1'b0;
                end
            end
            START: begin
                if (sample_mid && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_mid) begin
                    shreg_d   = {maj, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (bit_end && bit_cnt_q == BITS_FULL) begin
                    state_d    = (PARITY_MODE != int'(NONE)) ? PARITY : STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            PARITY: begin
                if (sample_mid) perr_d = ((^shreg_q) ^ maj) != (PARITY_MODE == int'(ODD));
                else if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (sample_mid) begin
                    if (!maj) ferr_d = 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        done_d = 1'b1;
                        if (ferr_q || !maj) begin
                            state_d  = WAIT_IDLE;
                            tick_clr = 1'b1;
                            phase_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Any low sample restarts the one-bit high qualification window.
                if (!rx_s_q) begin
                    tick_clr = 1'b1;
                    phase_d  = '0;
                end else if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        if (done_q) begin
            if (!valid_q || bus.rx_ready) begin
                data_d  = shreg_q;
                pe_d    = perr_q;
                fe_d    = ferr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.parity_error  = pe_q;
    assign bus.framing_error = fe_q;
    assign bus.overrun       = ovr_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench: 8N1 receiver (u0) and 8E1 receiver (u1) at 50 MHz / 115200 baud.
// One bit = 27 clocks/tick * 16 ticks = 432 clocks of 20 ns.
module tb_uart_rx_oversampled;
    localparam int BIT_CLKS = 432;
    localparam int TICK_CLKS = 27;

    logic clk;
    logic reset;
    int vectors = 0;
    int miscompares = 0;

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus1 ();

    uart_rx_oversampled #(.PARITY_MODE(0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    uart_rx_oversampled #(.PARITY_MODE(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Passive monitors: count rising edges of rx_valid, overrun cycles, busy cycles.
    logic v0_prev = 1'b0, v1_prev = 1'b0;
    int rises0 = 0, rises1 = 0, ovr0 = 0, busy0 = 0;
    logic [7:0] ld0 = '0, ld1 = '0;
    logic lpe0 = 1'b0, lfe0 = 1'b0, lpe1 = 1'b0, lfe1 = 1'b0;
    time rise_t0 = 0;
    time t_sof = 0;

    always @(negedge clk) begin
        v0_prev <= bus0.rx_valid;
        v1_prev <= bus1.rx_valid;
        if (bus0.rx_valid && !v0_prev) begin
            rises0  <= rises0 + 1;
            ld0     <= bus0.rx_data;
            lpe0    <= bus0.parity_error;
            lfe0    <= bus0.framing_error;
            rise_t0 <= $time;
        end
        if (bus1.rx_valid && !v1_prev) begin
            rises1 <= rises1 + 1;
            ld1    <= bus1.rx_data;
            lpe1   <= bus1.parity_error;
            lfe1   <= bus1.framing_error;
        end
        if (bus0.overrun) ovr0 <= ovr0 + 1;
        if (bus0.busy) busy0 <= busy0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) bus0.rx = b;
        else            bus1.rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_head(input int which, input logic [7:0] d);
        t_sof = $time;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop);
        send_head(which, d);
        if (use_par) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    int r0, o0, b0, lat, waited;

    initial begin
        reset = 1'b1;
        bus0.rx = 1'b1; bus0.rx_ready = 1'b0;
        bus1.rx = 1'b1; bus1.rx_ready = 1'b0;
        idle_clks(5);
        check("rst_data",  bus0.rx_data, 0);
        check("rst_valid", bus0.rx_valid, 0);
        check("rst_pe",    bus0.parity_error, 0);
        check("rst_fe",    bus0.framing_error, 0);
        check("rst_ovr",   bus0.overrun, 0);
        check("rst_busy",  bus0.busy, 0);
        reset = 1'b0;
        idle_clks(BIT_CLKS);

        // 8N1 0xA5, consumer always ready
        bus0.rx_ready = 1'b1;
        r0 = rises0;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        check("a5_count", rises0 - r0, 1);
        check("a5_data",  ld0, 8'hA5);
        check("a5_pe",    lpe0, 0);
        check("a5_fe",    lfe0, 0);
        check("a5_valid_dropped", bus0.rx_valid, 0);
        // ~9.5 bits to the stop-bit centre, plus sync/resolve/load latency of a few ticks
        lat = int'((rise_t0 - t_sof) / 20);
        check("a5_latency_window", (lat >= 19 * BIT_CLKS / 2) && (lat <= 19 * BIT_CLKS / 2 + 4 * TICK_CLKS), 1);

        // Even parity: 0x3C has four ones, so correct parity bit is 0
        bus1.rx_ready = 1'b1;
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
        idle_clks(BIT_CLKS);
        check("par_bad_data", ld1, 8'h3C);
        check("par_bad_pe",   lpe1, 1);
        check("par_bad_fe",   lfe1, 0);
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        check("par_ok_data", ld1, 8'h3C);
        check("par_ok_pe",   lpe1, 0);
        check("par_ok_count", rises1, 2);

        // Framing error followed by a long break
        r0 = rises0;
        send_frame(0, 8'h55, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive_bit(0, 1'b0);
        check("brk_busy_low", bus0.busy, 1);
        check("brk_count", rises0 - r0, 1);
        check("brk_data",  ld0, 8'h55);
        check("brk_fe",    lfe0, 1);
        check("brk_pe",    lpe0, 0);
        bus0.rx = 1'b1;
        idle_clks(BIT_CLKS / 2);
        check("brk_half_high_busy", bus0.busy, 1);
        idle_clks(BIT_CLKS);
        check("brk_recovered_idle", bus0.busy, 0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        check("post_brk_data", ld0, 8'h5A);
        check("post_brk_fe",   lfe0, 0);

        // 2 us glitch: false start rejected at mid-bit
        r0 = rises0; b0 = busy0;
        bus0.rx = 1'b0;
        idle_clks(100);
        bus0.rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("glitch_no_word", rises0 - r0, 0);
        check("glitch_busy_short", ((busy0 - b0) > 0) && ((busy0 - b0) < BIT_CLKS), 1);

        // Overrun: consumer stalled across two frames
        bus0.rx_ready = 1'b0;
        r0 = rises0; o0 = ovr0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        check("ovr_pulses", ovr0 - o0, 1);
        check("ovr_held_data", bus0.rx_data, 8'h11);
        check("ovr_held_valid", bus0.rx_valid, 1);
        check("ovr_count", rises0 - r0, 1);

        // Accept coinciding with the next load: ready raised only in the load cycle
        o0 = ovr0;
        send_head(0, 8'h22);
        bus0.rx = 1'b1;
        waited = 0;
        while (bus0.busy && waited < BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        check("sim_busy_timeout", waited < BIT_CLKS, 1);
        bus0.rx_ready = 1'b1;
        @(negedge clk);
        bus0.rx_ready = 1'b0;
        idle_clks(BIT_CLKS);
        check("sim_data",  bus0.rx_data, 8'h22);
        check("sim_valid", bus0.rx_valid, 1);
        check("sim_no_ovr", ovr0 - o0, 0);
        bus0.rx_ready = 1'b1;
        idle_clks(4);
        check("sim_drained", bus0.rx_valid, 0);

        // Reset in the middle of the data bits
        r0 = rises0;
        t_sof = $time;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'(8'h77 >> i));
        reset = 1'b1;
        idle_clks(5);
        check("mid_rst_data",  bus0.rx_data, 0);
        check("mid_rst_valid", bus0.rx_valid, 0);
        check("mid_rst_busy",  bus0.busy, 0);
        check("mid_rst_ovr",   bus0.overrun, 0);
        check("mid_rst_fe",    bus0.framing_error, 0);
        bus0.rx = 1'b1;
        reset = 1'b0;
        idle_clks(BIT_CLKS);
        check("mid_rst_no_partial", rises0 - r0, 0);
        send_frame(0, 8'h0F, 0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        check("after_rst_count", rises0 - r0, 1);
        check("after_rst_data",  ld0, 8'h0F);
        check("after_rst_fe",    lfe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
